// File: rtl/uart_cmd_bridge.sv
// Serial debug bridge: polls a UART register port, parses "Waaaadddddddd\r" / "Raaaa\r"
// lines and performs one 32-bit host access per line, answering through the UART TX FIFO.
module uart_cmd_bridge #(
    parameter logic [3:0] STAT_ADDR = 4'h0,
    parameter logic [3:0] RXD_ADDR  = 4'h1,
    parameter logic [3:0] TXD_ADDR  = 4'h1,
    parameter int         RXE_BIT   = 0,
    parameter int         TXF_BIT   = 1,
    parameter int         TIMEOUT   = 1024
) (
    input  logic        app_clk,
    input  logic        reset,
    output logic        u_reg_cs,
    output logic        u_reg_wr,
    output logic [3:0]  u_reg_addr,
    output logic [7:0]  u_reg_wdata,
    output logic        u_reg_be,
    input  logic [7:0]  u_reg_rdata,
    input  logic        u_reg_ack,
    output logic        h_req,
    output logic        h_wr,
    output logic [15:0] h_addr,
    output logic [31:0] h_wdata,
    input  logic [31:0] h_rdata,
    input  logic        h_ack
);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {RX_STAT, RX_DATA, PARSE, HOST, RESP, TX_STAT, TX_DATA} state_t;
    typedef enum logic [1:0] {R_WOK, R_ROK, R_ERR, R_TMO} resp_t;

    state_t      state;
    resp_t       resp;
    logic [7:0]  ch;
    logic [3:0]  cnt;
    logic        err;
    logic        cmd_wr;
    logic [15:0] addr_sr;
    logic [31:0] data_sr;
    logic [15:0] timer;
    logic [31:0] rdata_q;
    logic [3:0]  idx;

    logic        hex_ok;
    logic [3:0]  nib;
    logic        expect_cr;
    logic [3:0]  resp_len;
    logic [31:0] rsh;
    logic [7:0]  tx_char;

    assign u_reg_be  = u_reg_cs;
    assign expect_cr = cmd_wr ? (cnt == 4'd13) : (cnt == 4'd5);
    assign resp_len  = (resp == R_ROK) ? 4'd10 : 4'd3;
    assign rsh       = rdata_q << {idx[2:0], 2'b00};

    always_comb begin
        hex_ok = 1'b1;
        nib    = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39)
            nib = ch[3:0];
        else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
            nib = ch[3:0] + 4'd9;
        else
            hex_ok = 1'b0;
    end

    // The last two characters of every response are CR LF; the body depends on the outcome.
    always_comb begin
        tx_char = LF;
        if (idx == resp_len - 4'd1)
            tx_char = LF;
        else if (idx == resp_len - 4'd2)
            tx_char = CR;
        else begin
            case (resp)
                R_WOK:   tx_char = 8'h4B;
                R_ERR:   tx_char = 8'h3F;
                R_TMO:   tx_char = 8'h54;
                default: tx_char = (rsh[31:28] < 4'd10) ? {4'h3, rsh[31:28]}
                                                       : 8'h37 + {4'h0, rsh[31:28]};
            endcase
        end
    end

    always_ff @(posedge app_clk) begin
        if (reset) begin
            state       <= RX_STAT;
            resp        <= R_WOK;
            u_reg_cs    <= 1'b0;
            u_reg_wr    <= 1'b0;
            u_reg_addr  <= 4'h0;
            u_reg_wdata <= 8'h00;
            h_req       <= 1'b0;
            h_wr        <= 1'b0;
            h_addr      <= 16'h0;
            h_wdata     <= 32'h0;
            ch          <= 8'h00;
            cnt         <= 4'd0;
            err         <= 1'b0;
            cmd_wr      <= 1'b0;
            addr_sr     <= 16'h0;
            data_sr     <= 32'h0;
            timer       <= 16'h0;
            rdata_q     <= 32'h0;
            idx         <= 4'd0;
        end else begin
            case (state)
                RX_STAT, TX_STAT: begin
                    // cs drops on the ack edge, so the re-issue below leaves one idle cycle
                    if (!u_reg_cs) begin
                        u_reg_cs   <= 1'b1;
                        u_reg_wr   <= 1'b0;
                        u_reg_addr <= STAT_ADDR;
                    end else if (u_reg_ack) begin
                        u_reg_cs <= 1'b0;
                        if (state == RX_STAT && !u_reg_rdata[RXE_BIT])
                            state <= RX_DATA;
                        else if (state == TX_STAT && !u_reg_rdata[TXF_BIT])
                            state <= TX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!u_reg_cs) begin
                        u_reg_cs   <= 1'b1;
                        u_reg_wr   <= 1'b0;
                        u_reg_addr <= RXD_ADDR;
                    end else if (u_reg_ack) begin
                        u_reg_cs <= 1'b0;
                        ch       <= u_reg_rdata;
                        state    <= PARSE;
                    end
                end
                PARSE: begin
                    if (ch == LF && cnt == 4'd0 && !err) begin
                        state <= RX_STAT;
                    end else if (ch == CR) begin
                        cnt <= 4'd0;
                        err <= 1'b0;
                        if (!err && cnt != 4'd0 && expect_cr) begin
                            state   <= HOST;
                            h_req   <= 1'b1;
                            h_wr    <= cmd_wr;
                            h_addr  <= addr_sr;
                            h_wdata <= data_sr;
                            timer   <= 16'h0;
                        end else begin
                            resp  <= R_ERR;
                            state <= RESP;
                        end
                    end else begin
                        state <= RX_STAT;
                        if (!err) begin
                            if (cnt == 4'd0) begin
                                if (ch == 8'h57 || ch == 8'h77) begin
                                    cmd_wr <= 1'b1;
                                    cnt    <= 4'd1;
                                end else if (ch == 8'h52 || ch == 8'h72) begin
                                    cmd_wr <= 1'b0;
                                    cnt    <= 4'd1;
                                end else
                                    err <= 1'b1;
                            end else if (expect_cr || !hex_ok) begin
                                err <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                                if (cnt <= 4'd4)
                                    addr_sr <= {addr_sr[11:0], nib};
                                else
                                    data_sr <= {data_sr[27:0], nib};
                            end
                        end
                    end
                end
                HOST: begin
                    if (h_ack) begin
                        rdata_q <= h_rdata;
                        h_req   <= 1'b0;
                        resp    <= h_wr ? R_WOK : R_ROK;
                        state   <= RESP;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        h_req <= 1'b0;
                        resp  <= R_TMO;
                        state <= RESP;
                    end else
                        timer <= timer + 16'd1;
                end
                RESP: begin
                    idx   <= 4'd0;
                    state <= TX_STAT;
                end
                TX_DATA: begin
                    if (!u_reg_cs) begin
                        u_reg_cs    <= 1'b1;
                        u_reg_wr    <= 1'b1;
                        u_reg_addr  <= TXD_ADDR;
                        u_reg_wdata <= tx_char;
                    end else if (u_reg_ack) begin
                        u_reg_cs <= 1'b0;
                        u_reg_wr <= 1'b0;
                        if (idx == resp_len - 4'd1)
                            state <= RX_STAT;
                        else begin
                            idx   <= idx + 4'd1;
                            state <= TX_STAT;
                        end
                    end
                end
                default: state <= RX_STAT;
            endcase
        end
    end
endmodule

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Command bridge that sits directly on the register-bus slave port of the UART core. It polls the UART's status and RX data registers, and parses ASCII hex command lines. Each valid command becomes a single 32-bit access on a host-side master port. The ASCII response is pushed back through the UART's TX data register. This gives a debug/boot path into the SoC register space over the serial line, with no CPU involvement.

## Interface
Parameters:
- STAT_ADDR, 4'h0, UART status register address
- RXD_ADDR, 4'h1, UART RX data register address (read pops RX FIFO)
- TXD_ADDR, 4'h1, UART TX data register address (write pushes TX FIFO)
- RXE_BIT, 0, status bit index: RX FIFO empty
- TXF_BIT, 1, status bit index: TX FIFO full
- TIMEOUT, 1024, host-access timeout in app_clk cycles (1..65535)

Ports:
- app_clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- u_reg_cs  out  1  UART reg chip select
- u_reg_wr  out  1  1=write, 0=read
- u_reg_addr  out  4  UART reg address
- u_reg_wdata  out  8  UART write data
- u_reg_be  out  1  byte enable; driven 1 whenever u_reg_cs=1
- u_reg_rdata  in  8  UART read data, valid with u_reg_ack
- u_reg_ack  in  1  UART access complete
- h_req  out  1  host access request
- h_wr  out  1  1=write, 0=read
- h_addr  out  16  host address
- h_wdata  out  32  host write data
- h_rdata  in  32  host read data, valid with h_ack
- h_ack  in  1  host access complete

## Operation
- Reset: all outputs 0; FSM to RX_STAT; parser count 0, error flag 0.
- UART access rule: one access at a time. cs/wr/addr/wdata are stable from assertion until the cycle u_reg_ack=1. rdata is captured on that edge. cs is 0 for at least one cycle between accesses.
- FSM states and transitions:
  - RX_STAT: read STAT_ADDR. If rdata[RXE_BIT]=1, re-enter RX_STAT; else go to RX_DATA.
  - RX_DATA: read RXD_ADDR, then go to PARSE.
  - PARSE (1 cycle): consume the character. On line end go to HOST or RESP; otherwise go to RX_STAT.
  - HOST: access on the host port.
  - RESP: load the response string.
  - TX_STAT: read STAT_ADDR. If rdata[TXF_BIT]=1, re-enter TX_STAT; else go to TX_DATA.
  - TX_DATA: write the next char to TXD_ADDR. Loop TX_STAT/TX_DATA until the response is done, then go to RX_STAT.
- Line grammar (hex digits 0-9, A-F, a-f):
  - 'W'/'w' + 4 addr digits + 8 data digits + CR(0x0D)
  - 'R'/'r' + 4 addr digits + CR
  - Digits are shifted in MSB first.
  - LF(0x0A) received at count 0 is discarded silently.
- Errors:
  - Any unexpected char sets the error flag, e.g. bad command letter, non-hex digit, CR early, or a char where CR was expected.
  - While the flag is set, chars are consumed until CR, with no host access.
  - Response is "?\r\n"; then the flag and count are cleared.
- Host access:
  - h_req=1 with h_wr/h_addr/h_wdata stable until h_ack.
  - h_rdata is captured on the h_ack edge; h_req=0 the next cycle.
  - A 16-bit timer counts cycles with h_req=1. When it reaches TIMEOUT with no ack, h_req drops and the response is "T\r\n". An h_ack arriving after that is ignored.
- Responses:
  - Write OK: "K\r\n".
  - Read OK: 8 upper-case hex chars of h_rdata, MSB nibble first, then "\r\n".
  - Max response length 10 chars; a char index counter selects the next byte.

## Timing
- Minimum UART poll: 2 cycles per access (cs cycle + ack cycle when ack is registered), plus 1 idle cycle.
- Latency from CR read to h_req=1: 2 cycles (PARSE, then HOST entry).
- h_req rises at most once per command; no back-to-back host requests without an intervening response.
- Reset asserted mid-operation: on that edge, all outputs are 0 and any in-flight UART or host access is abandoned. A partial line is discarded.
- TX full held indefinitely: the FSM stalls in TX_STAT and RX is not polled. Response char order is preserved.

## Test plan
- Write: RX stream "W0010DEADBEEF\r", h_ack after 3 cycles -> exactly one h_req with h_wr=1, h_addr=0x0010, h_wdata=0xDEADBEEF; then TXD writes 0x4B, 0x0D, 0x0A.
- Read, mixed case: "r00a4\r", h_rdata=0x12345ABC -> h_wr=0, h_addr=0x00A4; TXD writes "12345ABC\r\n".
- Error: "W00G0DEADBEEF\r" -> no h_req; TXD writes "?\r\n". A following "R0000\r" is still served normally. A leading "\n" is ignored.
- Timeout: TIMEOUT=16, h_ack tied 0 -> h_req high for exactly 16 cycles, then 0; TXD writes "T\r\n". A late h_ack has no effect.
- Backpressure: status TXF_BIT=1 for 50 polls during a read response -> zero TXD writes while full; then all 10 chars in order. No RXD reads occur meanwhile.
- Reset mid-host-access and mid-line: all outputs 0 on the reset edge. A new "R0004\r" after reset is handled correctly.
